// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants, stall vectors and state encodings for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic     Stop        = 1'b1;
    localparam logic     NoStop      = 1'b0;
    localparam logic     RstEnable   = 1'b0;
    localparam int       InstAddrBus = 32;
    localparam logic [InstAddrBus-1:0] ZeroWord = '0;

    // bit0 = pc ... bit5 = WB; an older requester also holds every younger stage
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_DRAIN = 2'd1,
        PC_FLUSH = 2'd2
    } pc_state_t;

    function automatic logic [5:0] stall_merge(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        if (req_mem)     return STALL_MEM;
        else if (req_ex) return STALL_EX;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// rtl/pipe_ctrl_stall_counter.sv - saturating event counter with synchronous clear
module stall_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (i_rst_n == RstEnable) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall merge, trap drain/flush sequencing and branch redirect
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   n_rst_i,
    input  logic                   stallreq_if_i,
    input  logic                   stallreq_id_i,
    input  logic                   stallreq_ex_i,
    input  logic                   stallreq_mem_i,
    input  logic                   mem_busy_i,
    input  logic                   branch_i,
    input  logic [InstAddrBus-1:0] branch_addr_i,
    input  logic                   trap_i,
    input  logic [InstAddrBus-1:0] trap_addr_i,
    input  logic                   cnt_clr_i,
    output logic [5:0]             stall_o,
    output logic                   flush_o,
    output logic                   redirect_o,
    output logic [InstAddrBus-1:0] new_pc_o,
    output logic                   trap_busy_o,
    output logic [CNT_W-1:0]       stall_cycles_o
);

    pc_state_t               r_state;
    pc_state_t               w_state_nxt;
    logic [InstAddrBus-1:0]  r_trap_pc_q;
    logic [5:0]              w_stall_req;

    assign w_stall_req = stall_merge(stallreq_if_i, stallreq_id_i,
                                     stallreq_ex_i, stallreq_mem_i);

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (n_rst_i == RstEnable) begin
            r_state     <= PC_IDLE;
            r_trap_pc_q <= ZeroWord;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == PC_IDLE && trap_i) begin
                r_trap_pc_q <= trap_addr_i;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PC_IDLE:  if (trap_i) w_state_nxt = mem_busy_i ? PC_DRAIN : PC_FLUSH;
            PC_DRAIN: if (!mem_busy_i) w_state_nxt = PC_FLUSH;
            PC_FLUSH: w_state_nxt = PC_IDLE;
            default:  w_state_nxt = PC_IDLE;
        endcase
    end

    // A same-cycle branch loses to the trap: the trap belongs to an older instruction
    always_comb begin
        stall_o    = w_stall_req;
        flush_o    = 1'b0;
        redirect_o = 1'b0;
        new_pc_o   = ZeroWord;
        case (r_state)
            PC_IDLE: begin
                if (trap_i) begin
                    stall_o = w_stall_req | STALL_EX;
                end else if (branch_i) begin
                    redirect_o = 1'b1;
                    new_pc_o   = branch_addr_i;
                end
            end
            PC_DRAIN: stall_o = STALL_EX;
            PC_FLUSH: begin
                stall_o    = STALL_NONE;
                flush_o    = 1'b1;
                redirect_o = 1'b1;
                new_pc_o   = r_trap_pc_q;
            end
            default: stall_o = w_stall_req;
        endcase
    end

    assign trap_busy_o = (r_state != PC_IDLE);

    stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .i_clk   (clk_i),
        .i_rst_n (n_rst_i),
        .i_clr   (cnt_clr_i),
        .i_inc   (stall_o[1] == Stop),
        .o_cnt   (stall_cycles_o)
    );

endmodule
